arb_requester: RTL and testbench
================================

ARB_REQUESTER -- requirements
Module: arb_requester

Interface
REQ-001 Parameter MAX_LEN, default 16, SHALL set the maximum number of beats per transfer.
REQ-002 Parameter TIMEOUT, default 64, SHALL set the number of wait cycles before a grant timeout (used only with REQ_TIMEOUT_EN).
REQ-003 Port clk, input, 1, SHALL be the single clock; all logic is rising-edge.
REQ-004 Port reset, input, 1, SHALL be the synchronous, active-low reset.
REQ-005 Port cmd_valid, input, 1, SHALL indicate that a transfer command is offered.
REQ-006 Port cmd_len, input, 5, SHALL give the requested beat count (0..31).
REQ-007 Port cmd_ready, output, 1, SHALL indicate that a command can be accepted.
REQ-008 Port req, output, 1, SHALL be the bus request to the arbiter's rN input.
REQ-009 Port gnt, input, 1, SHALL be the grant from the arbiter's gN output.
REQ-010 Port beat_en, output, 1, SHALL strobe one data beat per cycle.
REQ-011 Port busy, output, 1, SHALL be high whenever the state is not IDLE.
REQ-012 Port done, output, 1, SHALL pulse once on successful completion.
REQ-013 Port err_timeout, output, 1, SHALL pulse once on grant timeout.

Function
REQ-014 The FSM SHALL have four states: IDLE, REQUEST, XFER, RELEASE; all outputs SHALL be registered.
REQ-015 cmd_ready SHALL equal (state==IDLE); a command SHALL be accepted on cmd_valid && cmd_ready, latching len = min(cmd_len, MAX_LEN).
REQ-016 An accepted command with len 0 SHALL stay in IDLE, never assert req, and pulse done the next cycle.
REQ-017 An accepted command with len >= 1 SHALL enter REQUEST with req=1 on the next cycle (1-cycle latency).
REQ-018 In REQUEST, gnt sampled high SHALL move the FSM to XFER; beat_en SHALL be high in every XFER cycle in which gnt is high.
REQ-019 If gnt drops during XFER, beat_en SHALL deassert that cycle, the beat count SHALL hold, req SHALL stay high, and beats SHALL resume when gnt returns.
REQ-020 On the cycle carrying beat number len, the FSM SHALL enter RELEASE with req=0 registered on the following cycle; exactly len beats SHALL be issued.
REQ-021 In RELEASE, the FSM SHALL wait for gnt==0, then return to IDLE and pulse done for 1 cycle, so the arbiter always observes a request drop before any new request.
REQ-022 gnt high while in IDLE SHALL be ignored (no beat_en, no state change).
REQ-023 The beat counter SHALL be 5 bits wide, SHALL never wrap, and SHALL clear on entry to REQUEST.
REQ-024 done and err_timeout SHALL never be high in the same cycle.

Reset
REQ-025 When reset==0 at a clock edge, the FSM SHALL enter IDLE, clear all counters, and drive req=0, beat_en=0, done=0, err_timeout=0, busy=0, and cmd_ready=1 on the next cycle.
REQ-026 A reset applied in the middle of a transfer SHALL abort it immediately without pulsing done; the beat count of the aborted transfer is discarded.

Configuration
REQ-027 With REQ_TIMEOUT_EN defined, a wait counter SHALL run only in REQUEST, clear on entry to REQUEST, and after TIMEOUT cycles with gnt low SHALL drop req, pulse err_timeout, and enter RELEASE; this path SHALL NOT pulse done.
REQ-028 With REQ_TIMEOUT_EN undefined, REQUEST SHALL wait indefinitely, the wait counter SHALL be absent, and err_timeout SHALL be tied 0.

Verification
REQ-029 The bench SHALL cover: cmd_len=3 with gnt high 1 cycle after req -> exactly 3 consecutive beat_en, req drops, gnt released -> done pulses once.
REQ-030 The bench SHALL cover: cmd_len=4 with gnt low for 2 cycles after beat 2 -> beat_en gaps for 2 cycles, 4 beats total, req stays high throughout.
REQ-031 The bench SHALL cover: cmd_len=0 -> req never asserts, done pulses the cycle after acceptance.
REQ-032 The bench SHALL cover: cmd_len=31 -> exactly 16 beats (MAX_LEN saturation).
REQ-033 The bench SHALL cover: reset=0 during beat 2 of 5 -> req=0, beat_en=0, cmd_ready=1 on the next cycle, and no done pulse.
REQ-034 The bench SHALL cover, with REQ_TIMEOUT_EN: gnt held low -> after 64 REQUEST cycles req drops, err_timeout pulses once, done stays 0, and the FSM returns to IDLE.

Source files
------------

// File: rtl/arb_requester.sv
// arb_requester: single-transfer bus requester FSM; define REQ_TIMEOUT_EN to add a grant-wait timeout
module arb_requester #(
    parameter int MAX_LEN = 16,
    parameter int TIMEOUT = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    input  logic [4:0] cmd_len,
    output logic       cmd_ready,
    output logic       req,
    input  logic       gnt,
    output logic       beat_en,
    output logic       busy,
    output logic       done,
    output logic       err_timeout
);
    typedef enum logic [1:0] {IDLE, REQUEST, XFER, RELEASE} state_t;
    state_t state, state_n;
    logic [4:0] len, len_n, cnt, cnt_n, len_sat;
    logic req_n, beat_n, done_n;
    assign len_sat = (cmd_len > 5'(MAX_LEN)) ? 5'(MAX_LEN) : cmd_len;
`ifdef REQ_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wait_cnt, wait_n;
    logic aborted, aborted_n, tmo_n;
`endif
    always_comb begin
        state_n = state;
        len_n   = len;
        cnt_n   = cnt;
        req_n   = req;
        beat_n  = 1'b0;
        done_n  = 1'b0;
`ifdef REQ_TIMEOUT_EN
        wait_n    = wait_cnt;
        aborted_n = aborted;
        tmo_n     = 1'b0;
`endif
        case (state)
            IDLE: if (cmd_valid) begin
                len_n = len_sat;
                if (len_sat == 5'd0) begin
                    done_n = 1'b1;
                end else begin
                    state_n = REQUEST;
                    req_n   = 1'b1;
                    cnt_n   = 5'd0;
`ifdef REQ_TIMEOUT_EN
                    wait_n    = '0;
                    aborted_n = 1'b0;
`endif
                end
            end
            REQUEST: if (gnt) begin
                state_n = XFER;
                beat_n  = 1'b1;
                cnt_n   = cnt + 5'd1;
            end
`ifdef REQ_TIMEOUT_EN
            else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                state_n   = RELEASE;
                req_n     = 1'b0;
                tmo_n     = 1'b1;
                aborted_n = 1'b1;
            end else begin
                wait_n = wait_cnt + 1'b1;
            end
`endif
            // the last beat cycle keeps req high; req falls as RELEASE is entered
            XFER: if (cnt == len) begin
                state_n = RELEASE;
                req_n   = 1'b0;
            end else if (gnt) begin
                beat_n = 1'b1;
                cnt_n  = cnt + 5'd1;
            end
            RELEASE: if (!gnt) begin
                state_n = IDLE;
`ifdef REQ_TIMEOUT_EN
                done_n = !aborted;
`else
                done_n = 1'b1;
`endif
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            len       <= 5'd0;
            cnt       <= 5'd0;
            req       <= 1'b0;
            beat_en   <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            state     <= state_n;
            len       <= len_n;
            cnt       <= cnt_n;
            req       <= req_n;
            beat_en   <= beat_n;
            done      <= done_n;
            busy      <= state_n != IDLE;
            cmd_ready <= state_n == IDLE;
        end
    end
`ifdef REQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt    <= '0;
            aborted     <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            wait_cnt    <= wait_n;
            aborted     <= aborted_n;
            err_timeout <= tmo_n;
        end
    end
`else
    assign err_timeout = 1'b0;
`endif
endmodule

// File: tb/tb_arb_requester.sv
// tb_arb_requester: randomized and directed transfers against a transaction-level requester model
module tb_arb_requester;
    localparam int MAX_LEN = 16;
    localparam int TIMEOUT = 64;
    logic clk = 1'b0, reset = 1'b0, cmd_valid = 1'b0, gnt = 1'b0;
    logic [4:0] cmd_len = 5'd0;
    logic cmd_ready, req, beat_en, busy, done, err_timeout;
    int n_chk = 0, n_err = 0;
    arb_requester #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_len(cmd_len),
        .cmd_ready(cmd_ready), .req(req), .gnt(gnt), .beat_en(beat_en),
        .busy(busy), .done(done), .err_timeout(err_timeout)
    );
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    // Model: a beat follows every granted requesting cycle until len beats are done;
    // req falls the cycle after the last beat, done follows the first gnt-low cycle after that.
    task automatic do_xfer(input int clen, input int pct, input int drop_at, input int drop_len);
        int exp_beats, beats, seen, dropped, ncyc;
        bit rq, rel, fin, g, eb, ed, drop;
        exp_beats = (clen > MAX_LEN) ? MAX_LEN : clen;
        beats = 0; seen = 0; dropped = 0; ncyc = 0;
        rq = 1'b1; rel = 1'b0; fin = 1'b0;
        check("accept_ready", cmd_ready, 1);
        gnt = 1'b0; cmd_len = 5'(clen); cmd_valid = 1'b1;
        step();
        cmd_valid = 1'b0;
        if (exp_beats == 0) begin
            check("zero_done", done, 1);
            check("zero_req", req, 0);
            check("zero_busy", busy, 0);
            step();
            check("zero_done_once", done, 0);
            check("zero_req_later", req, 0);
            return;
        end
        check("req_rise", req, 1);
        check("busy_rise", busy, 1);
        check("ready_low", cmd_ready, 0);
        while (!fin && ncyc < 500) begin
            if (rq) begin
                if (beats == drop_at && dropped < drop_len) begin
                    g = 1'b0;
                    dropped++;
                end else begin
                    g = ($urandom_range(1, 100) <= pct);
                end
            end else begin
                g = ($urandom_range(0, 3) == 0);
            end
            gnt = g;
            step();
            ncyc++;
            eb   = rq && g && beats < exp_beats;
            drop = rq && beats == exp_beats;
            ed   = rel && !g;
            if (eb) beats++;
            rq  = rq && !drop;
            rel = drop || (rel && g);
            fin = ed;
            seen += int'(beat_en);
            check("beat_en", beat_en, eb);
            check("req", req, rq);
            check("done", done, ed);
            check("busy", busy, rq || rel);
            check("cmd_ready", cmd_ready, !(rq || rel));
            check("err_timeout", err_timeout, 0);
        end
        gnt = 1'b0;
        check("xfer_finished", fin, 1);
        check("beat_total", seen, exp_beats);
    endtask
    initial begin
        int n, k, rc, ec, dc;
        repeat (3) step();
        check("rst_req", req, 0);
        check("rst_beat", beat_en, 0);
        check("rst_done", done, 0);
        check("rst_err", err_timeout, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", cmd_ready, 1);
        reset = 1'b1;
        gnt = 1'b1;
        repeat (3) begin
            step();
            check("idle_gnt_beat", beat_en, 0);
            check("idle_gnt_req", req, 0);
            check("idle_gnt_ready", cmd_ready, 1);
        end
        gnt = 1'b0;
        step();
        do_xfer(3, 100, -1, 0);
        do_xfer(4, 100, 2, 2);
        do_xfer(0, 100, -1, 0);
        do_xfer(31, 100, -1, 0);
        do_xfer(1, 50, -1, 0);
        do_xfer(16, 100, -1, 0);
        for (int i = 0; i < 20; i++)
            do_xfer($urandom_range(0, 31), $urandom_range(30, 100), -1, 0);
        cmd_len = 5'd5; cmd_valid = 1'b1; gnt = 1'b1;
        step();
        cmd_valid = 1'b0;
        n = 0; k = 0;
        while (n < 2 && k < 20) begin
            step();
            n += int'(beat_en);
            k++;
        end
        check("rst_reach_beat2", n, 2);
        reset = 1'b0;
        step();
        check("abort_req", req, 0);
        check("abort_beat", beat_en, 0);
        check("abort_ready", cmd_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        reset = 1'b1; gnt = 1'b0;
        repeat (3) begin
            step();
            check("abort_no_done", done, 0);
            check("abort_no_req", req, 0);
        end
        do_xfer(2, 100, -1, 0);
`ifdef REQ_TIMEOUT_EN
        cmd_len = 5'd3; cmd_valid = 1'b1; gnt = 1'b0;
        step();
        cmd_valid = 1'b0;
        rc = 0; ec = 0; dc = 0; k = 0;
        while (req && k < 200) begin
            rc++;
            step();
            k++;
            ec += int'(err_timeout);
            dc += int'(done);
        end
        check("tmo_err_at_drop", err_timeout, 1);
        repeat (3) begin
            step();
            ec += int'(err_timeout);
            dc += int'(done);
        end
        check("tmo_req_cycles", rc, TIMEOUT);
        check("tmo_err_count", ec, 1);
        check("tmo_done_count", dc, 0);
        check("tmo_idle", cmd_ready, 1);
        check("tmo_req_low", req, 0);
        do_xfer(3, 100, -1, 0);
`else
        rc = 0; ec = 0; dc = 0;
        check("no_tmo_err", err_timeout, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
